// File: rtl/cv32e40n_data_arb.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40n_data_arb
// Brief    : N-master to 1-slave OBI data-bus arbiter with pipelined issue
//            and in-order response routing through a master-ID FIFO.
// Revision : 1.0
// ============================================================================
module cv32e40n_data_arb #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 0
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NUM_MASTERS-1:0]                   m_req_i,
    output logic [NUM_MASTERS-1:0]                   m_gnt_o,
    output logic [NUM_MASTERS-1:0]                   m_rvalid_o,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS-1:0]                   m_we_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_rdata_o,
    output logic                                     s_req_o,
    input  logic                                     s_gnt_i,
    input  logic                                     s_rvalid_i,
    output logic [ADDR_WIDTH-1:0]                    s_addr_o,
    output logic                                     s_we_o,
    output logic [DATA_WIDTH/8-1:0]                  s_be_o,
    output logic [DATA_WIDTH-1:0]                    s_wdata_o,
    input  logic [DATA_WIDTH-1:0]                    s_rdata_i,
    output logic                                     rsp_err_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_err_q;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] head;
    logic             issue;
    logic             accept;
    logic             fifo_empty;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    generate
        if (ARB_MODE == 1) begin : g_rr
            logic [IDX_W-1:0] rr_ptr_q;

            // Scan offsets downwards so the nearest requester after the pointer wins.
            always_comb begin
                int cand;
                winner = '0;
                for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                    cand = int'(rr_ptr_q) + i;
                    if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
                    if (m_req_i[cand]) winner = IDX_W'(cand);
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rr_ptr_q <= '0;
                end else if (accept) begin
                    rr_ptr_q <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
                end
            end
        end else begin : g_fixed
            always_comb begin
                winner = '0;
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (m_req_i[i]) winner = IDX_W'(i);
                end
            end
        end
    endgenerate

    // A locked address phase bypasses the outstanding check: it was admitted
    // when it started and the count can only have dropped since.
    assign sel        = (state_q == ST_LOCK) ? lock_idx_q : winner;
    assign issue      = rst_ni && ((state_q == ST_LOCK) || ((|m_req_i) && (count_q < MAX_CNT)));
    assign accept     = issue && s_gnt_i;
    assign fifo_empty = (count_q == '0);
    assign pop        = s_rvalid_i && !fifo_empty;
    assign head       = fifo_q[rptr_q];

    assign s_req_o   = issue;
    assign s_addr_o  = issue ? m_addr_i[sel]  : '0;
    assign s_we_o    = issue ? m_we_i[sel]    : 1'b0;
    assign s_be_o    = issue ? m_be_i[sel]    : '0;
    assign s_wdata_o = issue ? m_wdata_i[sel] : '0;
    assign rsp_err_o = rsp_err_q;

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (issue && (sel == IDX_W'(i))) m_gnt_o[i] = s_gnt_i;
            if (!fifo_empty && (head == IDX_W'(i))) begin
                m_rvalid_o[i] = s_rvalid_i;
                m_rdata_o[i]  = s_rdata_i;
            end
        end
    end

    always_comb begin
        wptr_d = accept ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ARB;
            lock_idx_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rsp_err_q  <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (issue && !s_gnt_i) begin
                        state_q    <= ST_LOCK;
                        lock_idx_q <= winner;
                    end
                end
                ST_LOCK: begin
                    if (s_gnt_i) state_q <= ST_ARB;
                end
                default: state_q <= ST_ARB;
            endcase
            if (accept) fifo_q[wptr_q] <= sel;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (s_rvalid_i && fifo_empty) rsp_err_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire
